// File: rtl/sys_array_result_drain.sv
// Result-matrix drain: snapshots the fetcher's output matrix on array_ready rise and
// streams it row-major over valid/ready. Optional checksum output: SYS_ARRAY_DRAIN_CSUM_EN.
module sys_array_result_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W_W  = 20,
    parameter int ARRAY_A_L  = 10,
    parameter int ADDR_WIDTH = $clog2(ARRAY_W_W * ARRAY_A_L)
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  array_ready,
    input  logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0] array_data,
    output logic                                                  wr_valid,
    input  logic                                                  wr_ready,
    output logic [2*DATA_WIDTH-1:0]                               wr_data,
    output logic [ADDR_WIDTH-1:0]                                 wr_addr,
    output logic                                                  wr_last,
    output logic                                                  busy,
    output logic                                                  done,
    output logic                                                  overrun,
`ifdef SYS_ARRAY_DRAIN_CSUM_EN
    output logic [31:0]                                           csum,
`endif
    output logic [1:0]                                            dbg_state
);

    localparam int EW = 2 * DATA_WIDTH;
    localparam int RW = (ARRAY_W_W > 1) ? $clog2(ARRAY_W_W) : 1;
    localparam int CW = (ARRAY_A_L > 1) ? $clog2(ARRAY_A_L) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Handshake: an element transfers on any rising edge where wr_valid & wr_ready;
    // once wr_valid is high, data/addr/last are held until that transfer happens.
    state_t                                       r_state;
    state_t                                       w_next;
    logic                                         r_rdy_d;
    logic                                         r_overrun;
    logic [RW-1:0]                                r_row;
    logic [CW-1:0]                                r_col;
    logic [ADDR_WIDTH-1:0]                        r_addr;
    logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][EW-1:0]  r_buf;
    logic                                         w_rise;
    logic                                         w_capture;
    logic                                         w_fire;
    logic                                         w_last;

    assign w_rise    = array_ready & ~r_rdy_d;
    // A rise while streaming is refused so the snapshot being drained stays intact.
    assign w_capture = w_rise & (r_state != S_STREAM);
    assign w_last    = (r_state == S_STREAM) && (r_row == RW'(ARRAY_W_W - 1))
                       && (r_col == CW'(ARRAY_A_L - 1));
    assign w_fire    = (r_state == S_STREAM) & wr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_capture) w_next = S_STREAM;
            S_STREAM: if (w_fire && w_last) w_next = S_DONE;
            S_DONE:   w_next = w_capture ? S_STREAM : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        wr_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        wr_data  = '0;
        wr_addr  = '0;
        wr_last  = 1'b0;
        case (r_state)
            S_STREAM: begin
                wr_valid = 1'b1;
                busy     = 1'b1;
                wr_data  = r_buf[r_row][r_col];
                wr_addr  = r_addr;
                wr_last  = w_last;
            end
            S_DONE:   done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdy_d   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_rdy_d <= array_ready;
            if (w_rise && (r_state == S_STREAM)) r_overrun <= 1'b1;
        end
    end

    // Counters stop on the last element, so they never step past the final address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= '0;
        end else if (w_capture) begin
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= '0;
        end else if (w_fire && !w_last) begin
            r_addr <= r_addr + 1'b1;
            if (r_col == CW'(ARRAY_A_L - 1)) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) r_buf <= array_data;
    end

`ifdef SYS_ARRAY_DRAIN_CSUM_EN
    logic [31:0] r_csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csum <= '0;
        end else if (w_capture) begin
            r_csum <= '0;
        end else if (w_fire) begin
            r_csum <= r_csum + 32'(wr_data);
        end
    end

    assign csum = r_csum;
`endif

    assign overrun   = r_overrun;
    assign dbg_state = r_state;

endmodule
